// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
//   Bundles everything the arbiter exchanges with its two requesters
//   (instruction fetch and load/store) and with the single-port SRAM.
//
//   Fetch side    : inst_req, inst_addr -> inst_addr_ok, inst_data_ok, inst_rdata
//   Load/store    : data_req, data_wr, data_wstrb, data_addr, data_wdata
//                   -> data_addr_ok, data_data_ok, data_rdata
//   SRAM side     : sram_en, sram_we, sram_addr, sram_wdata <- sram_rdata
//
//   slave  : the arbiter's view (takes requests, drives grants and SRAM controls)
//   master : the environment's view (requesters plus the SRAM itself)
interface sram_port_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        input  sram_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        output sram_rdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
//   Shares one single-port SRAM between the instruction fetch port and the
//   load/store port. At most one access is granted per cycle; load/store
//   normally wins, but once STARVE_MAX consecutive data grants have been made
//   while a fetch is waiting, the fetch is forced through. Every granted
//   access gets its data_ok exactly one cycle later, routed back to whichever
//   port owned the grant.
//
//   Parameters
//     STARVE_MAX : data grants tolerated back-to-back while inst_req waits (1..15)
//   Ports
//     clk  : clock, rising edge
//     rst  : synchronous, active-high reset
//     bus  : sram_port_arbiter_if.slave (requests, grants, responses, SRAM controls)
module sram_port_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    sram_port_arbiter_if.slave bus
);

    localparam logic [1:0] OWNER_NONE = 2'd0;
    localparam logic [1:0] OWNER_INST = 2'd1;
    localparam logic [1:0] OWNER_DATA = 2'd2;

    localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

    logic [1:0] owner;
    logic [3:0] starve_cnt;
    logic       starved;
    logic       inst_grant;
    logic       data_grant;

    // Data has priority unless the fetch has already been passed over
    // STARVE_LIMIT times in a row. Both grants are forced low during reset so
    // nothing reaches the SRAM while the owner register is being cleared.
    always_comb begin
        starved    = bus.inst_req && (starve_cnt == STARVE_LIMIT);
        inst_grant = !rst && bus.inst_req && (starved || !bus.data_req);
        data_grant = !rst && bus.data_req && !inst_grant;
    end

    // Steer the winning request onto the SRAM. Address and write data are
    // zeroed when idle so the bus is quiet during reset and between accesses.
    always_comb begin
        bus.sram_en    = 1'b0;
        bus.sram_we    = 4'h0;
        bus.sram_addr  = 32'h0;
        bus.sram_wdata = 32'h0;
        if (inst_grant) begin
            bus.sram_en   = 1'b1;
            bus.sram_addr = bus.inst_addr;
        end else if (data_grant) begin
            bus.sram_en    = 1'b1;
            bus.sram_addr  = bus.data_addr;
            bus.sram_wdata = bus.data_wdata;
            bus.sram_we    = bus.data_wr ? bus.data_wstrb : 4'h0;
        end
    end

    assign bus.inst_addr_ok = inst_grant;
    assign bus.data_addr_ok = data_grant;

    // The owner register says who issued last cycle's access. Gating with rst
    // drops the response of a grant made just before reset asserted.
    assign bus.inst_data_ok = !rst && (owner == OWNER_INST);
    assign bus.data_data_ok = !rst && (owner == OWNER_DATA);

    assign bus.inst_rdata = bus.sram_rdata;
    assign bus.data_rdata = bus.sram_rdata;

    // Owner is rewritten every cycle so a new grant can overlap the response
    // of the previous one. The starvation count only grows while a fetch is
    // actually waiting; it can never pass STARVE_LIMIT because reaching it
    // forces an inst grant, which clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWNER_NONE;
            starve_cnt <= 4'd0;
        end else begin
            if (inst_grant) begin
                owner <= OWNER_INST;
            end else if (data_grant) begin
                owner <= OWNER_DATA;
            end else begin
                owner <= OWNER_NONE;
            end

            if (inst_grant || !bus.inst_req) begin
                starve_cnt <= 4'd0;
            end else if (data_grant) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
//   Drives the arbiter with a short directed sequence followed by a long
//   randomized run (requesters hold their request until granted, occasional
//   resets). A small SRAM model answers the arbiter's accesses; a reference
//   model tracks which port should win, what the SRAM holds and which
//   response is due, and a compare process checks the DUT every cycle.
module tb_sram_port_arbiter;

    localparam int STARVE_MAX = 4;

    localparam int RESP_NONE  = 0;
    localparam int RESP_INST  = 1;
    localparam int RESP_LOAD  = 2;
    localparam int RESP_STORE = 3;

    logic clk = 1'b0;
    logic rst;

    int compared   = 0;
    int mismatched = 0;

    sram_port_arbiter_if bus();

    sram_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seedWord(int i);
        return 32'hA5000000 ^ (32'(i) * 32'h00010203);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        checkOutput(name, 32'(act), 32'(exp));
    endtask

    // Simple synchronous SRAM: 64 words, read data one cycle after access,
    // reloaded with a known pattern whenever reset is held.
    logic [31:0] mem [64];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= seedWord(i);
        end else if (bus.sram_en) begin
            bus.sram_rdata <= mem[bus.sram_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (bus.sram_we[b]) mem[bus.sram_addr[7:2]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [64];
    int          waited_grants = 0;
    int          pend_kind     = RESP_NONE;
    logic [31:0] pend_val      = 32'h0;
    byte         model_log[$];
    byte         dut_log[$];

    always @(negedge clk) begin : compare_proc
        logic        inst_win;
        logic        data_win;
        logic [3:0]  exp_we;
        logic [31:0] exp_addr;
        int          idx;

        if (rst) begin
            checkFlag("rst_inst_addr_ok", bus.inst_addr_ok, 1'b0);
            checkFlag("rst_data_addr_ok", bus.data_addr_ok, 1'b0);
            checkFlag("rst_inst_data_ok", bus.inst_data_ok, 1'b0);
            checkFlag("rst_data_data_ok", bus.data_data_ok, 1'b0);
            checkFlag("rst_sram_en", bus.sram_en, 1'b0);
            checkOutput("rst_sram_we", 32'(bus.sram_we), 32'h0);
            checkOutput("rst_sram_addr", bus.sram_addr, 32'h0);
            checkOutput("rst_sram_wdata", bus.sram_wdata, 32'h0);
            for (int i = 0; i < 64; i++) ref_mem[i] = seedWord(i);
            waited_grants = 0;
            pend_kind     = RESP_NONE;
        end else begin
            // Who should win this cycle
            inst_win = bus.inst_req && (!bus.data_req || waited_grants >= STARVE_MAX);
            data_win = bus.data_req && !inst_win;
            exp_we   = 4'h0;
            exp_addr = 32'h0;
            if (inst_win) exp_addr = bus.inst_addr;
            if (data_win) begin
                exp_addr = bus.data_addr;
                exp_we   = bus.data_wr ? bus.data_wstrb : 4'h0;
            end

            checkFlag("inst_addr_ok", bus.inst_addr_ok, inst_win);
            checkFlag("data_addr_ok", bus.data_addr_ok, data_win);
            checkFlag("one_grant", bus.inst_addr_ok & bus.data_addr_ok, 1'b0);
            checkFlag("sram_en", bus.sram_en, inst_win | data_win);
            checkOutput("sram_we", 32'(bus.sram_we), 32'(exp_we));
            if (inst_win || data_win) checkOutput("sram_addr", bus.sram_addr, exp_addr);
            if (data_win) checkOutput("sram_wdata", bus.sram_wdata, bus.data_wdata);

            // Response for last cycle's grant
            checkFlag("inst_data_ok", bus.inst_data_ok, pend_kind == RESP_INST);
            checkFlag("data_data_ok", bus.data_data_ok, pend_kind == RESP_LOAD || pend_kind == RESP_STORE);
            if (pend_kind == RESP_INST) checkOutput("inst_rdata", bus.inst_rdata, pend_val);
            if (pend_kind == RESP_LOAD) checkOutput("data_rdata", bus.data_rdata, pend_val);
            checkOutput("inst_rdata_pass", bus.inst_rdata, bus.sram_rdata);
            checkOutput("data_rdata_pass", bus.data_rdata, bus.sram_rdata);

            // Advance the model to the next cycle
            if (inst_win) begin
                pend_kind = RESP_INST;
                pend_val  = ref_mem[bus.inst_addr[7:2]];
                model_log.push_back("I");
            end else if (data_win) begin
                idx       = int'(bus.data_addr[7:2]);
                pend_val  = ref_mem[idx];
                pend_kind = bus.data_wr ? RESP_STORE : RESP_LOAD;
                if (bus.data_wr)
                    for (int b = 0; b < 4; b++)
                        if (bus.data_wstrb[b]) ref_mem[idx][8*b +: 8] = bus.data_wdata[8*b +: 8];
                model_log.push_back("D");
            end else begin
                pend_kind = RESP_NONE;
                model_log.push_back("-");
            end
            dut_log.push_back(bus.inst_addr_ok ? "I" : (bus.data_addr_ok ? "D" : "-"));

            if (!bus.inst_req || inst_win) waited_grants = 0;
            else if (data_win) waited_grants++;
        end
    end

    task automatic applyStimulus(input logic r, input logic ir, input logic [31:0] ia,
                                 input logic dr, input logic dw, input logic [3:0] ds,
                                 input logic [31:0] da, input logic [31:0] dd);
        @(posedge clk);
        #1;
        rst            = r;
        bus.inst_req   = ir;
        bus.inst_addr  = ia;
        bus.data_req   = dr;
        bus.data_wr    = dw;
        bus.data_wstrb = ds;
        bus.data_addr  = da;
        bus.data_wdata = dd;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin : stimulus
        string       exp_pattern;
        string       got_model;
        string       got_dut;
        logic        ir, dr, dw, r;
        logic [31:0] ia, da, dd;
        logic [3:0]  ds;
        logic        inst_done, data_done;

        rst            = 1'b1;
        bus.inst_req   = 1'b0;
        bus.inst_addr  = 32'h0;
        bus.data_req   = 1'b0;
        bus.data_wr    = 1'b0;
        bus.data_wstrb = 4'h0;
        bus.data_addr  = 32'h0;
        bus.data_wdata = 32'h0;

        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkFlag("reset_sram_en", bus.sram_en, 1'b0);

        // First cycle out of reset: no stray responses
        applyIdle();
        @(negedge clk);
        checkFlag("post_rst_inst_data_ok", bus.inst_data_ok, 1'b0);
        checkFlag("post_rst_data_data_ok", bus.data_data_ok, 1'b0);

        // Partial store
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h20, 32'hDEADBEEF);
        @(negedge clk);
        checkFlag("store_addr_ok", bus.data_addr_ok, 1'b1);
        checkOutput("store_we", 32'(bus.sram_we), 32'h3);
        checkOutput("store_wdata", bus.sram_wdata, 32'hDEADBEEF);
        checkOutput("store_addr", bus.sram_addr, 32'h20);
        applyIdle();
        @(negedge clk);
        checkFlag("store_data_ok", bus.data_data_ok, 1'b1);

        // Place an instruction word at word 0, then fetch it
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0, 32'h02800C0C);
        applyStimulus(1'b0, 1'b1, 32'h1C000000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkFlag("fetch_addr_ok", bus.inst_addr_ok, 1'b1);
        checkOutput("fetch_sram_addr", bus.sram_addr, 32'h1C000000);
        checkFlag("fetch_overlap_store_ok", bus.data_data_ok, 1'b1);
        applyIdle();
        @(negedge clk);
        checkFlag("fetch_data_ok", bus.inst_data_ok, 1'b1);
        checkOutput("fetch_rdata", bus.inst_rdata, 32'h02800C0C);

        // Both request: data wins, fetch follows
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        @(negedge clk);
        checkFlag("conflict_data_ok", bus.data_addr_ok, 1'b1);
        checkFlag("conflict_inst_ok", bus.inst_addr_ok, 1'b0);
        checkOutput("conflict_sram_addr", bus.sram_addr, 32'h100);
        checkOutput("conflict_sram_we", 32'(bus.sram_we), 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkFlag("conflict_data_data_ok", bus.data_data_ok, 1'b1);
        checkOutput("conflict_load_rdata", bus.data_rdata, 32'h02800C0C);
        checkFlag("conflict_inst_follows", bus.inst_addr_ok, 1'b1);
        applyIdle();

        // Starvation: both held high for ten cycles
        repeat (10) applyStimulus(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 4'h0, 32'h48, 32'h0);
        applyIdle();
        exp_pattern = "DDDDIDDDDI";
        got_model   = "";
        got_dut     = "";
        for (int i = 0; i < 10; i++) begin
            got_model = {got_model, string'(model_log[model_log.size() - 10 + i])};
            got_dut   = {got_dut, string'(dut_log[dut_log.size() - 10 + i])};
        end
        compared++;
        if (got_model != exp_pattern) begin
            mismatched++;
            $display("[TB] FAIL starve_model_pattern: actual=%s required=%s", got_model, exp_pattern);
        end
        compared++;
        if (got_dut != exp_pattern) begin
            mismatched++;
            $display("[TB] FAIL starve_dut_pattern: actual=%s required=%s", got_dut, exp_pattern);
        end

        // Back-to-back alternating grants
        applyStimulus(1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkFlag("b2b_c0_inst_addr_ok", bus.inst_addr_ok, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
        @(negedge clk);
        checkFlag("b2b_c1_inst_data_ok", bus.inst_data_ok, 1'b1);
        checkFlag("b2b_c1_data_addr_ok", bus.data_addr_ok, 1'b1);
        checkFlag("b2b_c1_data_data_ok", bus.data_data_ok, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h28, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        checkFlag("b2b_c2_data_data_ok", bus.data_data_ok, 1'b1);
        checkFlag("b2b_c2_inst_addr_ok", bus.inst_addr_ok, 1'b1);
        checkFlag("b2b_c2_inst_data_ok", bus.inst_data_ok, 1'b0);
        applyIdle();
        @(negedge clk);
        checkFlag("b2b_c3_inst_data_ok", bus.inst_data_ok, 1'b1);
        checkFlag("b2b_c3_data_data_ok", bus.data_data_ok, 1'b0);

        // Reset right after a data grant
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0);
        @(negedge clk);
        checkFlag("rstmid_grant", bus.data_addr_ok, 1'b1);
        applyStimulus(1'b1, 1'b1, 32'h34, 1'b1, 1'b1, 4'hF, 32'h38, 32'h1234);
        @(negedge clk);
        checkFlag("rstmid_data_ok_dropped", bus.data_data_ok, 1'b0);
        checkFlag("rstmid_no_data_grant", bus.data_addr_ok, 1'b0);
        checkFlag("rstmid_no_inst_grant", bus.inst_addr_ok, 1'b0);
        checkFlag("rstmid_sram_en", bus.sram_en, 1'b0);
        checkOutput("rstmid_sram_addr", bus.sram_addr, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h34, 1'b1, 1'b1, 4'hF, 32'h38, 32'h1234);
        applyIdle();
        @(negedge clk);
        checkFlag("rstmid_after_inst_data_ok", bus.inst_data_ok, 1'b0);
        checkFlag("rstmid_after_data_data_ok", bus.data_data_ok, 1'b0);

        // Randomized traffic; each requester holds its request until granted
        ir = 1'b0; ia = 32'h0;
        dr = 1'b0; dw = 1'b0; ds = 4'h0; da = 32'h0; dd = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            inst_done = rst || !bus.inst_req || bus.inst_addr_ok;
            data_done = rst || !bus.data_req || bus.data_addr_ok;
            r = ($urandom_range(0, 63) == 0);
            if (inst_done) begin
                ir = ($urandom_range(0, 3) != 0);
                ia = $urandom;
            end
            if (data_done) begin
                dr = ($urandom_range(0, 3) != 0);
                dw = $urandom_range(0, 1) == 1;
                ds = 4'($urandom);
                da = $urandom;
                dd = $urandom;
            end
            applyStimulus(r, ir, ia, dr, dw, ds, da, dd);
        end

        applyIdle();
        applyIdle();
        @(negedge clk);
        $display("[TB] random run complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 Parameter: STARVE_MAX, 4, maximum number of consecutive data grants made while inst_req is pending; legal range 1..15.
REQ-002 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: inst_req  input  1  fetch read request.
REQ-005 Port: inst_addr  input  32  fetch byte address.
REQ-006 Port: inst_addr_ok  output  1  fetch request granted this cycle.
REQ-007 Port: inst_data_ok  output  1  fetch read data valid this cycle.
REQ-008 Port: inst_rdata  output  32  fetch read data.
REQ-009 Port: data_req  input  1  load/store request from the EX stage.
REQ-010 Port: data_wr  input  1  1 = store, 0 = load.
REQ-011 Port: data_wstrb  input  4  store byte enables.
REQ-012 Port: data_addr  input  32  load/store byte address.
REQ-013 Port: data_wdata  input  32  store data.
REQ-014 Port: data_addr_ok  output  1  load/store request granted this cycle.
REQ-015 Port: data_data_ok  output  1  load data valid, or store completed, this cycle.
REQ-016 Port: data_rdata  output  32  load data.
REQ-017 Port: sram_en, sram_we, sram_addr, sram_wdata  output  1/4/32/32  single-port SRAM controls.
REQ-018 Port: sram_rdata  input  32  SRAM read data, valid one cycle after a read access.

Function
REQ-019 At most one SRAM access per cycle; the arbiter grants at most one of inst_addr_ok and data_addr_ok per cycle.
REQ-020 Grant is combinational from the requests and arbiter state; a requester holds req, addr, wr, wstrb and wdata stable until its addr_ok is seen.
REQ-021 Default priority: data over inst.
REQ-022 A 4-bit starvation counter increments on each data grant made while inst_req=1.
REQ-023 When the counter equals STARVE_MAX and inst_req=1, inst is granted regardless of data_req, and the counter clears.
REQ-024 The counter clears on any inst grant, and on any cycle with inst_req=0.
REQ-025 On an inst grant: sram_en=1, sram_we=4'h0, sram_addr=inst_addr.
REQ-026 On a data grant: sram_en=1, sram_addr=data_addr, sram_wdata=data_wdata; sram_we=data_wstrb if data_wr=1, else 4'h0.
REQ-027 With no grant: sram_en=0, sram_we=4'h0.
REQ-028 A 2-bit response-owner register records the grant: NONE, INST or DATA.
REQ-029 The owner register updates every cycle, giving back-to-back grants with a throughput of one per cycle.
REQ-030 The response appears exactly one cycle after its grant: inst_data_ok=1 if the owner is INST; data_data_ok=1 if the owner is DATA.
REQ-031 Stores also produce data_data_ok one cycle after their grant.
REQ-032 inst_rdata and data_rdata both pass sram_rdata through.
REQ-033 Requesters must accept data_ok unconditionally; the block has no response backpressure.
REQ-034 Simultaneous events: a response for grant N and the addr_ok for grant N+1 may occur in the same cycle, including to the same requester.
REQ-035 When both requests are low, there is no grant, the owner becomes NONE, and both data_ok are 0 in the next cycle.

Reset
REQ-036 While rst=1: all addr_ok and data_ok outputs are 0, sram_en=0, sram_we=4'h0, and sram_addr and sram_wdata are 0.
REQ-037 The first rising edge with rst=1 sets the owner to NONE and the counter to 0.
REQ-038 A grant issued in the cycle before rst asserts produces no data_ok; its response is discarded.
REQ-039 In the first cycle after rst deasserts, both data_ok are 0.

Verification
REQ-040 Inst-only: inst_req=1, inst_addr=0x1C000000, sram_rdata=0x02800C0C next cycle -> inst_addr_ok=1 in cycle 0; inst_data_ok=1 and inst_rdata=0x02800C0C in cycle 1.
REQ-041 Conflict: inst_req=data_req=1, data_wr=0, data_addr=0x100 -> data_addr_ok=1 and inst_addr_ok=0; sram_addr=0x100 and sram_we=0; data_data_ok=1 in the next cycle.
REQ-042 Starvation: both requests held high for 10 cycles with STARVE_MAX=4 -> grant pattern D,D,D,D,I,D,D,D,D,I; never two grants in one cycle.
REQ-043 Store: data_req=1, data_wr=1, data_wstrb=4'b0011, data_wdata=0xDEADBEEF, data_addr=0x20 -> sram_we=4'b0011 and sram_wdata=0xDEADBEEF in the grant cycle; data_data_ok=1 in the next cycle.
REQ-044 Back-to-back: alternate inst and data grants on consecutive cycles -> each data_ok lands exactly one cycle after its own grant, routed to the correct requester.
REQ-045 Reset mid-op: data grant in cycle 0, rst=1 in cycle 1 -> data_data_ok=0 in cycle 1; all outputs 0 until the first cycle after rst deasserts.
